cache_req_responder: RTL and testbench

//  Memory-side responder for the CPU request interface (Address/wr_rd/cs/DOut).

---
 rtl/cache_req_responder.sv | 206 ++++++++++++++++++++
 tb/tb_cache_req_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_responder.sv
// Direct-mapped, write-back, write-allocate byte cache controller.
// CPU hits are served from the on-chip data array. On a miss, a dirty victim line is written
// back first. The line is then filled from main memory over a strobe/ack byte interface.
// Optional feature: define CACHE_STATS_EN to add the saturating hit_cnt/miss_cnt outputs.
`timescale 1ns / 1ps

module cache_req_responder #(
  parameter int unsigned TAG_W    = 8,
  parameter int unsigned INDEX_W  = 3,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Address,
  input  logic        wr_rd,
  input  logic        cs,
  input  logic [7:0]  DOut,
  output logic [7:0]  rd_data,
  output logic        rdy,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_wr_rd,
  output logic        mem_strb,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  input  logic        mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int unsigned Lines = 1 << INDEX_W;
  localparam int unsigned Bytes = 1 << (INDEX_W + OFFSET_W);
  localparam logic [OFFSET_W-1:0] CntOne  = 1;
  localparam logic [OFFSET_W-1:0] CntLast = '1;

  if (TAG_W + INDEX_W + OFFSET_W != 16) begin : g_bad_params
    $error("cache_req_responder: TAG_W+INDEX_W+OFFSET_W must equal 16");
  end

  typedef enum logic [2:0] {StIdle, StLookup, StHit, StWrback, StFill, StDone} state_e;

  state_e state_q, state_d;

  logic [15:0]                     req_addr_q, req_addr_d;
  logic                            req_wr_q, req_wr_d;
  logic [7:0]                      req_data_q, req_data_d;
  logic [OFFSET_W-1:0]             cnt_q, cnt_d;
  logic [Lines-1:0]                valid_q, valid_d;
  logic [Lines-1:0]                dirty_q, dirty_d;
  logic [Lines-1:0][TAG_W-1:0]     tag_q, tag_d;
  logic [7:0]                      rd_data_q, rd_data_d;

  logic [7:0]                      data_q [Bytes];
  logic                            arr_we;
  logic [INDEX_W+OFFSET_W-1:0]     arr_waddr;
  logic [7:0]                      arr_wdata;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                hit;
  logic                xfer_done;

  assign req_tag   = req_addr_q[15 -: TAG_W];
  assign req_idx   = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_off   = req_addr_q[OFFSET_W-1:0];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // A byte completes only while the strobe is up; stray acks are ignored.
  assign xfer_done = mem_strb && mem_ack;
  assign rd_data   = rd_data_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state, datapath next values and memory-side outputs.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_wr_d   = req_wr_q;
    req_data_d = req_data_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    rd_data_d  = rd_data_q;
    arr_we     = 1'b0;
    arr_waddr  = {req_idx, req_off};
    arr_wdata  = req_data_q;
    mem_addr   = '0;
    mem_wr_rd  = 1'b0;
    mem_strb   = 1'b0;
    mem_dout   = '0;
    rdy        = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (cs) begin
          req_addr_d = Address;
          req_wr_d   = wr_rd;
          req_data_d = DOut;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        cnt_d = '0;
        if (hit)                   state_d = StHit;
        else if (dirty_q[req_idx]) state_d = StWrback;
        else                       state_d = StFill;
      end
      StWrback: begin
        mem_wr_rd = 1'b1;
        mem_strb  = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx, cnt_q};
        mem_dout  = data_q[{req_idx, cnt_q}];
        if (xfer_done) begin
          cnt_d = cnt_q + CntOne;
          if (cnt_q == CntLast) state_d = StFill;
        end
      end
      StFill: begin
        mem_strb = 1'b1;
        mem_addr = {req_tag, req_idx, cnt_q};
        if (xfer_done) begin
          arr_we    = 1'b1;
          arr_waddr = {req_idx, cnt_q};
          arr_wdata = mem_din;
          cnt_d     = cnt_q + CntOne;
          if (cnt_q == CntLast) begin
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b0;
            tag_d[req_idx]   = req_tag;
            state_d          = StHit;
          end
        end
      end
      StHit: begin
        // Write-allocate: a write miss merges its byte here, after the fill.
        if (req_wr_q) begin
          arr_we           = 1'b1;
          dirty_d[req_idx] = 1'b1;
        end else begin
          rd_data_d = data_q[{req_idx, req_off}];
        end
        state_d = StDone;
      end
      StDone: begin
        rdy     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Request capture, byte counter and line metadata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_q <= '0;
      req_wr_q   <= 1'b0;
      req_data_q <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      tag_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      req_addr_q <= req_addr_d;
      req_wr_q   <= req_wr_d;
      req_data_q <= req_data_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Data array: not reset, since stale contents are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (arr_we) data_q[arr_waddr] <= arr_wdata;
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters, updated once per lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StLookup) begin
      if (hit && hit_cnt_q != 16'hFFFF)    hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!hit && miss_cnt_q != 16'hFFFF)  miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_req_responder.sv
// Self-checking bench for cache_req_responder.
// The reference model tracks the CPU-visible memory image plus per-line valid, tag and dirty
// state. From these it predicts the read data and the exact memory traffic of each request.
`timescale 1ns / 1ps

module tb_cache_req_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Address;
  logic        wr_rd;
  logic        cs;
  logic [7:0]  DOut;
  logic [7:0]  rd_data;
  logic        rdy;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_wr_rd;
  logic        mem_strb;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  cache_req_responder dut (
    .clk      (clk),
    .rst      (rst),
    .Address  (Address),
    .wr_rd    (wr_rd),
    .cs       (cs),
    .DOut     (DOut),
    .rd_data  (rd_data),
    .rdy      (rdy),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wr_rd(mem_wr_rd),
    .mem_strb (mem_strb),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_ack  (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t      log_q[$];
  logic [7:0] backing [65536];  // main memory contents
  logic [7:0] shadow  [65536];  // what the CPU should observe
  logic       mvalid  [8];
  logic       mdirty  [8];
  logic [7:0] mtag    [8];

  // Main-memory responder: random ack delay, one ack per byte, ack dropped for a cycle
  // so the next address is always visible before the next ack. Occasional stray acks
  // while the strobe is low must be ignored by the DUT.
  initial begin
    mem_ack = 1'b0;
    mem_din = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst || mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_strb && $urandom_range(0, 2) != 0) begin
        if (mem_wr_rd) backing[mem_addr] = mem_dout;
        else           mem_din = backing[mem_addr];
        log_q.push_back({mem_wr_rd, mem_addr, mem_wr_rd ? mem_dout : backing[mem_addr]});
        mem_ack = 1'b1;
      end else if (!mem_strb && $urandom_range(0, 7) == 0) begin
        mem_din = 8'hEE;
        mem_ack = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Reset drops all cached lines; dirty bytes that never reached memory are lost.
  task automatic model_reset();
    for (int l = 0; l < 8; l++) begin
      if (mvalid[l] && mdirty[l]) begin
        for (int i = 0; i < 32; i++) begin
          logic [15:0] a;
          a = {mtag[l], 3'(l), 5'(i)};
          shadow[a] = backing[a];
        end
      end
      mvalid[l] = 1'b0;
      mdirty[l] = 1'b0;
    end
  endtask

  // One CPU request. The model predicts rd_data, hit latency and memory traffic.
  // With glitch set, a conflicting write request is pulsed on cs while the DUT is busy.
  task automatic do_req(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input bit glitch);
    xfer_t      exp_q[$];
    logic [2:0] idx;
    logic [7:0] tg;
    logic [7:0] exp_rd;
    bit         hit;
    bit         got;
    bit         bad;
    int         n;
    int         extra;
    idx = a[7:5];
    tg  = a[15:8];
    hit = mvalid[idx] && (mtag[idx] == tg);
    if (!hit) begin
      if (mvalid[idx] && mdirty[idx]) begin
        for (int i = 0; i < 32; i++) begin
          logic [15:0] wa;
          wa = {mtag[idx], idx, 5'(i)};
          exp_q.push_back({1'b1, wa, shadow[wa]});
        end
      end
      for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, tg, idx, 5'(i), 8'h00});
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdirty[idx] = 1'b0;
    end
    if (w) begin
      shadow[a]   = d;
      mdirty[idx] = 1'b1;
    end
    exp_rd = shadow[a];
    log_q.delete();

    @(negedge clk);
    Address = a;
    wr_rd   = w;
    DOut    = d;
    cs      = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 1000) begin
      @(negedge clk);
      cs = 1'b0;
      n++;
      if (rdy) got = 1'b1;
      else if (glitch && n == 4) begin
        Address = ~a;
        wr_rd   = 1'b1;
        DOut    = 8'h5A;
        cs      = 1'b1;
      end
    end

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rdy_timeout addr=%h: no rdy after %0d cycles, required one", a, n);
      return;
    end
    if (!w) begin
      checks++;
      if (rd_data !== exp_rd) begin
        errors++;
        $display("FAIL rd_data addr=%h got %h expected %h", a, rd_data, exp_rd);
      end
    end
    if (hit) begin
      checks++;
      if (n !== 3) begin
        errors++;
        $display("FAIL hit_latency addr=%h got %0d edges expected 3", a, n);
      end
    end
    checks++;
    bad = (log_q.size() != exp_q.size());
    if (bad) begin
      errors++;
      $display("FAIL mem_traffic_len addr=%h got %0d bytes expected %0d",
               a, log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size() && !bad; i++) begin
        if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr ||
            (exp_q[i].wr && log_q[i].data !== exp_q[i].data)) begin
          bad = 1'b1;
          errors++;
          $display("FAIL mem_traffic addr=%h byte %0d got wr=%b a=%h d=%h expected wr=%b a=%h d=%h",
                   a, i, log_q[i].wr, log_q[i].addr, log_q[i].data,
                   exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rdy_pulse addr=%h got rdy=%b busy=%b expected 0 0", a, rdy, busy);
    end
    if (glitch) begin
      extra = 0;
      repeat (10) begin
        @(negedge clk);
        if (rdy || busy) extra++;
      end
      checks++;
      if (extra != 0) begin
        errors++;
        $display("FAIL cs_while_busy got %0d extra busy/rdy cycles expected 0", extra);
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    cs      = 1'b0;
    wr_rd   = 1'b0;
    Address = 16'h0000;
    DOut    = 8'h00;
    #50;
    checks += 4;
    if (rdy !== 1'b0)      begin errors++; $display("FAIL reset_rdy got %b expected 0", rdy); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (mem_strb !== 1'b0) begin errors++; $display("FAIL reset_strb got %b expected 0", mem_strb); end
    if (mem_addr !== 16'h0 || rd_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_outs got mem_addr=%h rd_data=%h expected 0 0", mem_addr, rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Read miss, hit, write hit, read-back, then a dirty eviction of line 1.
  task automatic test_directed();
    do_req(16'h1234, 1'b0, 8'h00, 1'b0);
    do_req(16'h1234, 1'b0, 8'h00, 1'b0);
    do_req(16'h1234, 1'b1, 8'hA5, 1'b0);
    do_req(16'h1234, 1'b0, 8'h00, 1'b0);
    do_req(16'h5634, 1'b0, 8'h00, 1'b0);
    checks++;
    if (backing[16'h1234] !== 8'hA5) begin
      errors++;
      $display("FAIL writeback_data got %h expected a5", backing[16'h1234]);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stats got hit=%0d miss=%0d expected 3 2", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_cs_busy();
    do_req(16'h9A40, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    int n;
    log_q.delete();
    @(negedge clk);
    Address = 16'h7B64;
    wr_rd   = 1'b0;
    cs      = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    n  = 0;
    while (log_q.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (log_q.size() < 3 || mem_strb !== 1'b1) begin
      errors++;
      $display("FAIL fill_start got %0d bytes strb=%b expected >=3 and 1", log_q.size(), mem_strb);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_strb !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort got strb=%b busy=%b expected 0 0", mem_strb, busy);
    end
    @(negedge clk);
    checks++;
    if (mem_strb !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort_next got strb=%b expected 0", mem_strb);
    end
    rst = 1'b0;
    model_reset();
    do_req(16'h7B64, 1'b0, 8'h00, 1'b0);
    checks++;
    if (log_q.size() != 32) begin
      errors++;
      $display("FAIL miss_after_rst got %0d bytes expected 32", log_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    v = 8'($urandom);
    do_req(16'h2345, 1'b1, v, 1'b0);
    do_req(16'h2345, 1'b0, 8'h00, 1'b0);
    do_req(16'h2346, 1'b1, ~v, 1'b0);
    do_req(16'h2346, 1'b0, 8'h00, 1'b0);
    do_req(16'h2345, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] tags [4];
    tags[0] = 8'h12;
    tags[1] = 8'h56;
    tags[2] = 8'h9A;
    tags[3] = 8'hC3;
    for (int k = 0; k < 150; k++) begin
      logic [15:0] a;
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 5'($urandom)};
      do_req(a, 1'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      backing[i] = 8'(i);
      shadow[i]  = 8'(i);
    end
    for (int l = 0; l < 8; l++) begin
      mvalid[l] = 1'b0;
      mdirty[l] = 1'b0;
      mtag[l]   = 8'h00;
    end
    test_reset();
    test_directed();
    test_cs_busy();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
